// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS core's load/store bus unit: access sizes, FSM states and
// the alignment rule used to reject requests before they reach the bus.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeWordAlt = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StRdata,
        StResp
    } mem_state_t;

    // Encoding 2'b11 behaves exactly like a word access.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic mis;
        unique case (size)
            SizeByte: mis = 1'b0;
            SizeHalf: mis = addr_lo[0];
            default:  mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mips_cpu_mem_lane.sv
// Little-endian lane steering: byte enables and replicated write data for stores,
// lane extraction plus sign/zero extension for loads. Purely combinational.
module mips_cpu_mem_lane
    import mips_cpu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        byte_shift = rdata_raw_i >> {addr_lo_i, 3'b000};
        half_shift = rdata_raw_i >> {addr_lo_i[1], 4'b0000};
        load_byte  = byte_shift[7:0];
        load_half  = half_shift[15:0];
        be_o       = 4'b0000;
        wdata_o    = '0;
        rdata_o    = '0;
        unique case (mem_size_t'(size_i))
            SizeByte: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{signed_i & load_byte[7]}}, load_byte};
            end
            SizeHalf: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{signed_i & load_half[15]}}, load_half};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_raw_i;
            end
        endcase
    end

endmodule

// File: rtl/mips_cpu_mem_unit.sv
// Load/store bus unit: runs one core data request as a single Avalon-MM transfer and
// returns a done pulse with the extended load result (or err for misaligned requests).
module mips_cpu_mem_unit
    import mips_cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned CHECK_ALIGN = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  read_o,
    output logic                  write_o,
    output logic [3:0]            byteenable_o,
    output logic [31:0]           writedata_o,
    input  logic                  waitrequest_i,
    input  logic [31:0]           readdata_i
);

    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic                  write_q, write_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        misaligned;

    mips_cpu_mem_lane u_lane (
        .size_i      (size_q),
        .signed_i    (signed_q),
        .addr_lo_i   (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rdata_raw_i (readdata_i),
        .be_o        (lane_be),
        .wdata_o     (lane_wdata),
        .rdata_o     (lane_rdata)
    );

    assign misaligned = (CHECK_ALIGN != 0) &&
                        is_misaligned(mem_size_t'(req_size_i), req_addr_i[1:0]);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    write_d  = req_write_i;
                    wdata_d  = req_wdata_i;
                    err_d    = misaligned;
                    state_d  = misaligned ? StResp : StBus;
                end
            end
            StBus: begin
                if (!waitrequest_i) begin
                    state_d = write_q ? StResp : StRdata;
                end
            end
            StRdata: begin
                rdata_d = lane_rdata;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Bus outputs derive only from registered state, so they stay stable under waitrequest.
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StResp);
    assign err_o        = done_o & err_q;
    assign rdata_o      = rdata_q;
    assign address_o    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign read_o       = (state_q == StBus) & ~write_q;
    assign write_o      = (state_q == StBus) & write_q;
    assign byteenable_o = (state_q == StBus) ? lane_be : 4'b0000;
    assign writedata_o  = write_o ? lane_wdata : '0;

endmodule

// File: tb/tb_mips_cpu_mem_unit.sv
// Bench for mips_cpu_mem_unit: directed scenarios plus random requests against an
// arithmetic reference model of lane steering, extension, alignment and latency.
module tb_mips_cpu_mem_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_signed_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        busy_o, done_o, err_o, read_o, write_o;
    logic [31:0] rdata_o, address_o, writedata_o;
    logic [3:0]  byteenable_o;
    logic        waitrequest_i = 1'b0;
    logic [31:0] readdata_i = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = '0;

    always #5 clk_i = ~clk_i;

    mips_cpu_mem_unit #(
        .ADDR_WIDTH  (32),
        .CHECK_ALIGN (1)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_write_i   (req_write_i),
        .req_size_i    (req_size_i),
        .req_signed_i  (req_signed_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .rdata_o       (rdata_o),
        .address_o     (address_o),
        .read_o        (read_o),
        .write_o       (write_o),
        .byteenable_o  (byteenable_o),
        .writedata_o   (writedata_o),
        .waitrequest_i (waitrequest_i),
        .readdata_i    (readdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    function automatic int unsigned size_num(input logic [1:0] sz);
        return (sz == 2'b11) ? 2 : int'(sz);
    endfunction

    function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
        int unsigned n = size_num(sz);
        if (n == 1) return (a % 2) != 0;
        if (n == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a, input logic [31:0] rd);
        int unsigned n = size_num(sz);
        logic [31:0] v;
        if (n == 0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (sg && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (n == 1) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int unsigned n = size_num(sz);
        if (n == 0) return 32'(1 << (a % 4));
        if (n == 1) return ((a / 2) % 2) != 0 ? 32'hC : 32'h3;
        return 32'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
        int unsigned n = size_num(sz);
        if (n == 0) return (w & 32'hFF) * 32'h01010101;
        if (n == 1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    // Issues one request from an IDLE cycle and follows it to the IDLE cycle after done.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int nwait, input logic hold, input string tag);
        bit mis;
        int exp_lat;
        int c;
        int bus_cycles;
        int done_cyc;
        bit rd_fire;
        mis = ref_mis(sz, a);
        exp_lat = mis ? 1 : (wr ? 2 + nwait : 3 + nwait);
        req_write_i  = wr;
        req_size_i   = sz;
        req_signed_i = sg;
        req_addr_i   = a;
        req_wdata_i  = wd;
        req_valid_i  = 1'b1;
        cyc();
        req_valid_i  = hold;
        c = 1;
        bus_cycles = 0;
        done_cyc = 0;
        rd_fire = 1'b0;
        while (c <= 20 && done_cyc == 0) begin
            readdata_i = rd_fire ? rd : $urandom;
            rd_fire = 1'b0;
            chk({tag, " busy"}, 32'(busy_o), 32'h1);
            chk({tag, " rd&wr"}, 32'(read_o & write_o), 32'h0);
            if (read_o || write_o) begin
                chk({tag, " read"}, 32'(read_o), 32'(!wr));
                chk({tag, " write"}, 32'(write_o), 32'(wr));
                chk({tag, " address"}, address_o, a & 32'hFFFFFFFC);
                chk({tag, " be"}, 32'(byteenable_o), ref_be(sz, a));
                if (wr) chk({tag, " writedata"}, writedata_o, ref_wdata(sz, wd));
                waitrequest_i = (bus_cycles < nwait);
                if (!waitrequest_i && read_o) rd_fire = 1'b1;
                bus_cycles++;
            end else begin
                waitrequest_i = 1'($urandom % 2);
            end
            if (done_o) begin
                done_cyc = c;
                chk({tag, " err"}, 32'(err_o), 32'(mis));
                if (!mis && !wr) model_rdata = ref_load(sz, sg, a, rd);
                chk({tag, " rdata"}, rdata_o, model_rdata);
            end
            cyc();
            c++;
        end
        waitrequest_i = 1'b0;
        chk({tag, " latency"}, 32'(done_cyc), 32'(exp_lat));
        chk({tag, " bus_cycles"}, 32'(bus_cycles), mis ? 32'h0 : 32'(nwait + 1));
        chk({tag, " idle_busy"}, 32'(busy_o), 32'h0);
        chk({tag, " idle_done"}, 32'(done_o), 32'h0);
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst busy", 32'(busy_o), 32'h0);
        chk("rst done", 32'(done_o), 32'h0);
        chk("rst err", 32'(err_o), 32'h0);
        chk("rst rdata", rdata_o, 32'h0);
        chk("rst rw", {30'h0, read_o, write_o}, 32'h0);
        chk("rst address", address_o, 32'h0);
        chk("rst be", 32'(byteenable_o), 32'h0);
        chk("rst writedata", writedata_o, 32'h0);
        rst_ni = 1'b1;
        cyc();

        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, "t1_lw");
        do_req(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80112233, 0, 1'b0, "t2_lb");
        chk("t2 lb value", rdata_o, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80112233, 1, 1'b0, "t2_lbu");
        chk("t2 lbu value", rdata_o, 32'h00000080);
        do_req(1'b1, 2'b01, 1'b0, 32'h402, 32'h1234ABCD, 32'h0, 3, 1'b0, "t3_sh");
        chk("t3 rdata kept", rdata_o, 32'h00000080);
        do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h11111111, 0, 1'b0, "t4_lw_mis");
        do_req(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 32'h22222222, 0, 1'b0, "t4_lh_mis");
        do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h9ABC0000, 0, 1'b0, "t4_lh_ok");
        chk("t4 lh value", rdata_o, 32'hFFFF9ABC);
        do_req(1'b1, 2'b00, 1'b0, 32'h001, 32'h55, 32'h0, 0, 1'b1, "t5_sb_hold");
        do_req(1'b1, 2'b00, 1'b0, 32'h001, 32'h55, 32'h0, 0, 1'b0, "t5_sb_next");

        // Reset in the middle of a stalled load.
        req_write_i = 1'b0;
        req_size_i = 2'b10;
        req_addr_i = 32'h300;
        req_valid_i = 1'b1;
        waitrequest_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        chk("t6 read before", 32'(read_o), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6 read async", 32'(read_o), 32'h0);
        chk("t6 busy async", 32'(busy_o), 32'h0);
        chk("t6 address async", address_o, 32'h0);
        model_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6 no done", 32'(done_o), 32'h0);
        end
        waitrequest_i = 1'b0;
        rst_ni = 1'b1;
        cyc();
        chk("t6 idle", 32'(busy_o), 32'h0);
        chk("t6 rdata", rdata_o, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'hCAFEF00D, 2, 1'b0, "t6_after");

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom % 4);
            a = $urandom;
            do_req(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, $urandom,
                   int'($urandom % 4), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
